// File: rtl/serial_add_alu.sv
// Bit-serial adder/subtractor: one full-adder step per clock, LSB first,
// with a three-state IDLE/RUN/DONE sequencer and registered result flags.
module serial_add_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] r,
  output logic             co,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             co_q, co_d;
  logic             ovf_q, ovf_d;

  logic sum_bit, cout_bit;

  assign sum_bit  = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
  assign cout_bit = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    carry_d = carry_q;
    r_d     = r_q;
    co_d    = co_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      RUN: begin
        // Sum bits enter at the MSB of the A shifter, so after WIDTH steps it holds the result.
        a_sh_d  = {sum_bit, a_sh_q[WIDTH-1:1]};
        b_sh_d  = b_sh_q >> 1;
        carry_d = cout_bit;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          cnt_d   = '0;
          r_d     = {sum_bit, a_sh_q[WIDTH-1:1]};
          co_d    = cout_bit;
          ovf_d   = carry_q ^ cout_bit;
        end
      end
      default: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          a_sh_d  = a;
          // Subtract is a + ~b + 1: invert B and force the initial carry.
          b_sh_d  = op ? ~b : b;
          carry_d = op ? 1'b1 : ci;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      carry_q <= 1'b0;
      r_q     <= '0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      carry_q <= carry_d;
      r_q     <= r_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
    end
  end

  assign r    = r_q;
  assign co   = co_q;
  assign ovf  = ovf_q;
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_serial_add_alu.sv
// Scoreboard bench for serial_add_alu: directed corner cases, protocol
// abuse, mid-operation reset and random operations against an arithmetic model.
module tb_serial_add_alu;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ci;
  logic [W-1:0] r;
  logic         co;
  logic         ovf;
  logic         busy;
  logic         done;

  typedef struct packed {
    logic [W-1:0] r;
    logic         co;
    logic         ovf;
  } exp_t;

  exp_t         sb_q[$];
  int           checks   = 0;
  int           failures = 0;
  logic [W-1:0] last_r   = '0;

  serial_add_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .ci(ci),
    .r(r), .co(co), .ovf(ovf), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic longint to_signed(input logic [W-1:0] v);
    return v[W-1] ? longint'(v) - (longint'(1) << W) : longint'(v);
  endfunction

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic mop, input logic mci);
    exp_t   e;
    longint full;
    longint sres;
    if (!mop) begin
      full = longint'(ma) + longint'(mb) + longint'(mci);
      sres = to_signed(ma) + to_signed(mb) + longint'(mci);
    end else begin
      full = longint'(ma) + (longint'(1) << W) - longint'(mb);
      sres = to_signed(ma) - to_signed(mb);
    end
    e.r   = full[W-1:0];
    e.co  = full[W];
    e.ovf = (sres > (longint'(1) << (W - 1)) - 1) || (sres < -(longint'(1) << (W - 1)));
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0");
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("result_r_co_ovf", {r, co, ovf}, {e.r, e.co, e.ovf});
      end
    end
  end

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic top, input logic tci);
    exp_t e;
    a = ta; b = tb_v; op = top; ci = tci; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    e = model(ta, tb_v, top, tci);
    sb_q.push_back(e);
    check("busy_after_accept", busy, 1);
    check("done_after_accept", done, 0);
    a = W'($urandom); b = W'($urandom); op = 1'($urandom); ci = 1'($urandom);
    for (int i = 1; i < W; i++) begin
      @(posedge clk); #1;
      start = (i == 3);
      if (i == W / 2) begin
        check("busy_mid_run", busy, 1);
        check("r_held_mid_run", r, last_r);
      end
    end
    @(posedge clk); #1;
    start = 1'b0;
    check("done_at_n_plus_w", done, 1);
    check("busy_at_n_plus_w", busy, 0);
    last_r = e.r;
    @(posedge clk); #1;
    check("done_one_cycle", done, 0);
    check("idle_after_done", busy, 0);
  endtask

  initial begin
    exp_t e1, e2;
    rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0; ci = 1'b0;
    #2;
    check("reset_outputs", {r, co, ovf, busy, done}, '0);
    @(posedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    check("start_ignored_in_reset", busy, 0);
    start = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(8'h01, 8'h01, 1'b0, 1'b0);
    run_op(8'h7F, 8'h01, 1'b0, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 1'b0);
    run_op(8'hAA, 8'h55, 1'b0, 1'b1);
    run_op(8'h05, 8'h07, 1'b1, 1'b1);
    run_op(8'h80, 8'h01, 1'b1, 1'b0);

    // Back-to-back: start held high through DONE.
    a = 8'h3C; b = 8'h21; op = 1'b0; ci = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    e1 = model(8'h3C, 8'h21, 1'b0, 1'b1);
    sb_q.push_back(e1);
    a = 8'h10; b = 8'h20; op = 1'b1; ci = 1'b0;
    repeat (W - 1) @(posedge clk);
    #1;
    check("b2b_busy_first", busy, 1);
    @(posedge clk); #1;
    check("b2b_done_first", done, 1);
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_done_drops", done, 0);
    check("b2b_busy_again", busy, 1);
    e2 = model(8'h10, 8'h20, 1'b1, 1'b0);
    sb_q.push_back(e2);
    repeat (W - 1) @(posedge clk);
    @(posedge clk); #1;
    check("b2b_done_second", done, 1);
    last_r = e2.r;
    @(posedge clk); #1;

    // Reset four cycles into an operation aborts it.
    a = 8'h55; b = 8'h66; op = 1'b0; ci = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_outputs_zero", {r, co, ovf, busy, done}, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    last_r = '0;
    repeat (W + 2) @(posedge clk);
    #1;
    check("abort_no_done", done, 0);
    run_op(8'h03, 8'h04, 1'b0, 1'b0);

    for (int n = 0; n < 20; n++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
    end

    repeat (3) @(posedge clk);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_add_alu.md
SERIAL_ADD_ALU -- requirements
Module: serial_add_alu

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 The module SHALL have exactly these ports, clock and reset first:
 - clk    input   1      single clock, rising-edge active
 - rst    input   1      asynchronous, active-high reset
 - start  input   1      request to begin an operation; sampled on clk rising edge
 - op     input   1      0 = add (a+b+ci), 1 = subtract (a-b)
 - a      input   WIDTH  operand A
 - b      input   WIDTH  operand B
 - ci     input   1      carry-in for add; ignored when op=1
 - r      output  WIDTH  result register
 - co     output  1      carry-out of MSB (for subtract: 1 = no borrow)
 - ovf    output  1      signed overflow
 - busy   output  1      operation in progress
 - done   output  1      one-cycle completion pulse
REQ-003 One clock, clk; reset rst is asynchronous and active-high.

Function
REQ-004 Datapath SHALL be bit-serial: one full-adder step per cycle, LSB first, sum = x^y^c, carry = maj(x,y,c), single carry flip-flop.
REQ-005 FSM states: IDLE, RUN, DONE; busy = (state==RUN); done = (state==DONE).
REQ-006 Start accepted only at an edge with start=1 and busy=0 (IDLE or DONE); at that edge a, op, ci captured, state -> RUN, bit counter cleared.
REQ-007 Capture: A-shift <= a; B-shift <= b if op=0, ~b if op=1; carry <= ci if op=0, 1 if op=1.
REQ-008 start=1 while busy=1 SHALL be ignored; a, b, op, ci changes after acceptance SHALL NOT affect the result.
REQ-009 Each RUN edge processes one bit; after exactly WIDTH RUN edges state -> DONE.
REQ-010 Latency: accept at edge N; busy=1 after edges N..N+WIDTH-1; done=1 and busy=0 after edge N+WIDTH, for exactly one cycle.
REQ-011 r, co, ovf SHALL update only at the edge entering DONE and hold until the next completion or reset; intermediate shift state is not visible on r.
REQ-012 co = final carry; ovf = (carry into MSB) XOR (carry out of MSB).
REQ-013 DONE -> IDLE on the next edge unless start=1, in which case DONE -> RUN (back-to-back, done deasserts, busy asserts).
REQ-014 Result is modulo 2^WIDTH; no saturation.

Reset
REQ-015 rst=1 SHALL immediately (asynchronously) force state IDLE, r=0, co=0, ovf=0, busy=0, done=0, counter=0, shift/carry registers 0.
REQ-016 rst asserted mid-operation SHALL abort it: no done pulse, r not updated; first start after rst deasserts behaves per REQ-006.
REQ-017 start is ignored at any edge where rst=1.

Verification (WIDTH=8)
REQ-018 Add: a=8'h01, b=8'h01, ci=0, op=0, start at edge N -> busy high 8 cycles, done pulse after edge N+8, r=8'h02, co=0, ovf=0.
REQ-019 Carry/signed: a=8'h7F, b=8'h01, op=0 -> r=8'h80, co=0, ovf=1; a=8'hFF, b=8'h01 -> r=8'h00, co=1, ovf=0.
REQ-020 Carry-in: a=8'hAA, b=8'h55, ci=1, op=0 -> r=8'h00, co=1, ovf=0.
REQ-021 Subtract: a=8'h05, b=8'h07, op=1, ci=1 (ignored) -> r=8'hFE, co=0, ovf=0; a=8'h80, b=8'h01, op=1 -> r=8'h7F, co=1, ovf=1.
REQ-022 Protocol: start re-pulsed and a/b changed while busy -> no restart, original result delivered; start held high through DONE -> back-to-back op with done low next cycle.
REQ-023 Reset: rst pulsed 4 cycles into an operation -> all outputs 0 immediately, no done pulse; subsequent a=8'h03, b=8'h04 -> r=8'h07 after 8 cycles.
